// File: rtl/start_delay_timer_pkg.sv
// Shared definitions for the Tug-Of-War start referee: FSM state encoding
// and bit positions inside fs_player.
package start_delay_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GO     = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int FS_LEFT  = 0;
  localparam int FS_RIGHT = 1;

endpackage

// File: rtl/tow_tick_gen.sv
// Free-running prescaler: one registered tick pulse every PRESCALE cycles,
// restarted from zero whenever clr is held.
module tow_tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg == CNT_W'(PRESCALE - 1)) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/start_delay_timer.sv
// Random-delay referee: gathers RAND_BITS LFSR bits, holds off for
// (MIN_TICKS+R) ticks, then raises go; early presses end in FAULT.
module start_delay_timer
  import start_delay_timer_pkg::*;
#(
  parameter int RAND_BITS = 4,
  parameter int MIN_TICKS = 2,
  parameter int PRESCALE  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rand_bit,
  input  logic       start,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       round_done,
  output logic       go,
  output logic       busy,
  output logic       false_start,
  output logic [1:0] fs_player
);

  localparam int DLY_W = RAND_BITS + 1;
  localparam int BC_W  = $clog2(RAND_BITS) + 1;

  state_t               state_reg, state_next;
  logic [RAND_BITS-1:0] sreg_reg, sreg_next;
  logic [BC_W-1:0]      bitcnt_reg, bitcnt_next;
  logic [DLY_W-1:0]     delay_reg, delay_next;
  logic [1:0]           fs_reg, fs_next;
  logic                 go_reg, busy_reg, false_start_reg;
  logic                 tick;
  logic                 press;

  assign press = btn_l | btn_r;

  tow_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_reg != ST_WAIT),
    .tick(tick)
  );

  always_comb begin
    state_next  = state_reg;
    sreg_next   = sreg_reg;
    bitcnt_next = bitcnt_reg;
    delay_next  = delay_reg;
    fs_next     = fs_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_SAMPLE;
          sreg_next   = '0;
          bitcnt_next = '0;
        end
      end
      ST_SAMPLE: begin
        if (press) begin
          state_next         = ST_FAULT;
          fs_next[FS_LEFT]   = btn_l;
          fs_next[FS_RIGHT]  = btn_r;
        end else begin
          sreg_next = {sreg_reg[RAND_BITS-2:0], rand_bit};
          if (bitcnt_reg == BC_W'(RAND_BITS - 1)) begin
            delay_next = DLY_W'(MIN_TICKS) + DLY_W'(sreg_next);
            state_next = ST_WAIT;
          end else begin
            bitcnt_next = bitcnt_reg + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A press on the last tick wins over the transition to GO.
        if (press) begin
          state_next         = ST_FAULT;
          fs_next[FS_LEFT]   = btn_l;
          fs_next[FS_RIGHT]  = btn_r;
        end else if (tick) begin
          if (delay_reg == DLY_W'(1)) begin
            state_next = ST_GO;
          end else begin
            delay_next = delay_reg - 1'b1;
          end
        end
      end
      ST_GO: begin
        if (round_done) begin
          state_next = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (start) begin
          state_next  = ST_SAMPLE;
          fs_next     = 2'b00;
          sreg_next   = '0;
          bitcnt_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register, with no path from inputs to pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      sreg_reg        <= '0;
      bitcnt_reg      <= '0;
      delay_reg       <= '0;
      fs_reg          <= 2'b00;
      go_reg          <= 1'b0;
      busy_reg        <= 1'b0;
      false_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sreg_reg        <= sreg_next;
      bitcnt_reg      <= bitcnt_next;
      delay_reg       <= delay_next;
      fs_reg          <= fs_next;
      go_reg          <= (state_next == ST_GO);
      busy_reg        <= (state_next == ST_SAMPLE) || (state_next == ST_WAIT) ||
                         (state_next == ST_GO);
      false_start_reg <= (state_next == ST_FAULT);
    end
  end

  assign go          = go_reg;
  assign busy        = busy_reg;
  assign false_start = false_start_reg;
  assign fs_player   = fs_reg;

endmodule
